// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher sequencer slice.
//   seqState_t    : FSM state encoding (LOAD=0, RUN=1, DRAIN=2), exported on oState
//   DEF_WORD_W    : default data/key word width
//   DEF_KEY_WORDS : default key length in words (power of two, >= 2)
//   idxWidth()    : width of the key word index counters
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seqState_t;

    localparam int unsigned DEF_WORD_W    = 32;
    localparam int unsigned DEF_KEY_WORDS = 16;

    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xor_cipher_sequencer_if.sv
// Host/stream bus of the XOR cipher sequencer. Member names are seen from the
// sequencer's side (i* = into the sequencer, o* = out of it).
//   key load   : iKey_word, iKey_valid, oKey_ready
//   plaintext  : iData, iData_valid, oData_ready
//   ciphertext : oData, oData_valid, iData_ready
//   control    : iRekey, oState, oKey_loaded
// Modports: slave = sequencer, master = host/downstream environment.
interface xor_cipher_sequencer_if
    import xor_cipher_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] iKey_word;
    logic              iKey_valid;
    logic              oKey_ready;
    logic [WORD_W-1:0] iData;
    logic              iData_valid;
    logic              oData_ready;
    logic [WORD_W-1:0] oData;
    logic              oData_valid;
    logic              iData_ready;
    logic              iRekey;
    logic [1:0]        oState;
    logic              oKey_loaded;

    modport slave (
        input  iKey_word, iKey_valid, iData, iData_valid, iData_ready, iRekey,
        output oKey_ready, oData_ready, oData, oData_valid, oState, oKey_loaded
    );

    modport master (
        output iKey_word, iKey_valid, iData, iData_valid, iData_ready, iRekey,
        input  oKey_ready, oData_ready, oData, oData_valid, oState, oKey_loaded
    );
endinterface

// File: rtl/xor_cipher_sequencer_key_word_bank.sv
// key_word_bank: KEY_WORDS x WORD_W key register file.
//   iClk    : clock
//   iClr    : synchronous clear of every word (has priority over write)
//   iWe     : write enable
//   iWaddr  : write index
//   iWdata  : write data
//   iRaddr  : read index
//   oRdata  : combinational read data
module key_word_bank
    import xor_cipher_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned KEY_WORDS = DEF_KEY_WORDS
)(
    input  logic                              iClk,
    input  logic                              iClr,
    input  logic                              iWe,
    input  logic [idxWidth(KEY_WORDS)-1:0]    iWaddr,
    input  logic [WORD_W-1:0]                 iWdata,
    input  logic [idxWidth(KEY_WORDS)-1:0]    iRaddr,
    output logic [WORD_W-1:0]                 oRdata
);
    logic [WORD_W-1:0] keyMem [KEY_WORDS];

    always_ff @(posedge iClk) begin
        if (iClr) begin
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                keyMem[i] <= '0;
            end
        end else if (iWe) begin
            keyMem[iWaddr] <= iWdata;
        end
    end

    assign oRdata = keyMem[iRaddr];

endmodule

// File: rtl/xor_cipher_sequencer.sv
// xor_cipher_sequencer: loads a KEY_WORDS-word key, then XORs each accepted
// plaintext word with the next key word (rotating index) into a one-deep
// registered output stage. A rekey request drains the output stage, then
// returns to key loading.
//   iClk, iRst  : clock, synchronous active-high reset
//   bus (slave) : key load, plaintext in, ciphertext out, rekey, state/status
//   oWord_count : ciphertext words handed downstream, saturating; present only
//                 when XOR_CIPHER_WORD_COUNT_EN is defined
module xor_cipher_sequencer
    import xor_cipher_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned KEY_WORDS = DEF_KEY_WORDS
)(
    input  logic                   iClk,
    input  logic                   iRst,
    xor_cipher_sequencer_if.slave  bus
`ifdef XOR_CIPHER_WORD_COUNT_EN
    ,
    output logic [31:0]            oWord_count
`endif
);
    localparam int unsigned        IDX_W    = idxWidth(KEY_WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(KEY_WORDS - 1);

    seqState_t         state;
    seqState_t         stateNext;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  rdIdx;
    logic [WORD_W-1:0] keyRd;
    logic [WORD_W-1:0] dataOut;
    logic              dataOutValid;
    logic              keyReady;
    logic              dataReady;
    logic              keyHs;
    logic              dataHs;
    logic              outTaken;

    key_word_bank #(
        .WORD_W    (WORD_W),
        .KEY_WORDS (KEY_WORDS)
    ) uKeyBank (
        .iClk   (iClk),
        .iClr   (iRst),
        .iWe    (keyHs),
        .iWaddr (wrIdx),
        .iWdata (bus.iKey_word),
        .iRaddr (rdIdx),
        .oRdata (keyRd)
    );

    always_comb begin
        keyReady  = 1'b0;
        dataReady = 1'b0;
        stateNext = state;
        outTaken  = dataOutValid & bus.iData_ready;

        unique case (state)
            ST_LOAD: begin
                keyReady = 1'b1;
                if (bus.iKey_valid && (wrIdx == LAST_IDX)) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                // One-deep pipeline: a new word fits if the stage is empty or
                // is being emptied this cycle.
                dataReady = !dataOutValid || bus.iData_ready;
                if (bus.iRekey) begin
                    stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!dataOutValid) begin
                    stateNext = ST_LOAD;
                end
            end
            default: stateNext = ST_LOAD;
        endcase

        keyHs  = keyReady & bus.iKey_valid;
        dataHs = dataReady & bus.iData_valid;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_LOAD;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrIdx <= '0;
            rdIdx <= '0;
        end else begin
            if (keyHs) begin
                wrIdx <= wrIdx + 1'b1;
            end
            // The read index restarts with every freshly loaded key.
            if (keyHs && (wrIdx == LAST_IDX)) begin
                rdIdx <= '0;
            end else if (dataHs) begin
                rdIdx <= rdIdx + 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            dataOut      <= '0;
            dataOutValid <= 1'b0;
        end else if (dataHs) begin
            dataOut      <= bus.iData ^ keyRd;
            dataOutValid <= 1'b1;
        end else if (outTaken) begin
            dataOutValid <= 1'b0;
        end
    end

`ifdef XOR_CIPHER_WORD_COUNT_EN
    logic [31:0] wordCount;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wordCount <= '0;
        end else if ((state != ST_LOAD) && (stateNext == ST_LOAD)) begin
            wordCount <= '0;
        end else if (outTaken && (wordCount != '1)) begin
            wordCount <= wordCount + 1'b1;
        end
    end

    assign oWord_count = wordCount;
`endif

    assign bus.oKey_ready  = keyReady;
    assign bus.oData_ready = dataReady;
    assign bus.oData       = dataOut;
    assign bus.oData_valid = dataOutValid;
    assign bus.oState      = state;
    assign bus.oKey_loaded = (state == ST_RUN);

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Self-checking bench for xor_cipher_sequencer. A behavioural model (key array,
// mode, rotating index, one pending output word) predicts every output each
// cycle; directed sequences are followed by randomized traffic with occasional
// rekeys and resets. Honours XOR_CIPHER_WORD_COUNT_EN for the word counter.
module tb_xor_cipher_sequencer;
    localparam int unsigned W = 32;
    localparam int unsigned K = 16;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    xor_cipher_sequencer_if #(.WORD_W(W)) bus ();

`ifdef XOR_CIPHER_WORD_COUNT_EN
    logic [31:0] wordCount;
`endif

    xor_cipher_sequencer #(
        .WORD_W    (W),
        .KEY_WORDS (K)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
`ifdef XOR_CIPHER_WORD_COUNT_EN
        ,
        .oWord_count (wordCount)
`endif
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: 0=loading key, 1=running, 2=draining
    int          mMode;
    logic [31:0] mKey [K];
    int          mWr;
    int          mRd;
    bit          mOutValid;
    logic [31:0] mOut;
    longint      mCount;

    task automatic setIn(input bit kv, input logic [31:0] k, input bit dv,
                         input logic [31:0] d, input bit dr, input bit rk);
        bus.iKey_valid  = kv;
        bus.iKey_word   = k;
        bus.iData_valid = dv;
        bus.iData       = d;
        bus.iData_ready = dr;
        bus.iRekey      = rk;
    endtask

    // One clock: check readies against current inputs, advance model, clock,
    // then check registered outputs.
    task automatic cycle();
        bit keyHs, dataHs, taken, oldValid;
        #2;
        checkVal("key_ready", bus.oKey_ready, (mMode == 0));
        checkVal("data_ready", bus.oData_ready, (mMode == 1) && (!mOutValid || bus.iData_ready));
        if (iRst) begin
            mMode = 0; mWr = 0; mRd = 0; mOutValid = 0; mOut = '0; mCount = 0;
            for (int i = 0; i < K; i++) mKey[i] = '0;
        end else begin
            oldValid = mOutValid;
            keyHs  = (mMode == 0) && bus.iKey_valid;
            dataHs = (mMode == 1) && bus.iData_valid && (!mOutValid || bus.iData_ready);
            taken  = mOutValid && bus.iData_ready;
            if (taken && mCount < 64'hFFFF_FFFF) mCount++;
            if (dataHs) begin
                mOut = bus.iData ^ mKey[mRd];
                mRd = (mRd + 1) % K;
                mOutValid = 1;
            end else if (taken) begin
                mOutValid = 0;
            end
            case (mMode)
                0: if (keyHs) begin
                    mKey[mWr] = bus.iKey_word;
                    if (mWr == K - 1) begin mMode = 1; mRd = 0; end
                    mWr = (mWr + 1) % K;
                end
                1: if (bus.iRekey) mMode = 2;
                default: if (!oldValid) begin mMode = 0; mCount = 0; end
            endcase
        end
        @(posedge iClk);
        #1;
        checkVal("state", bus.oState, mMode);
        checkVal("key_loaded", bus.oKey_loaded, (mMode == 1));
        checkVal("out_valid", bus.oData_valid, mOutValid);
        checkVal("out_data", bus.oData, mOut);
`ifdef XOR_CIPHER_WORD_COUNT_EN
        checkVal("word_count", wordCount, mCount);
`endif
    endtask

    task automatic checkBankZero(input string tag);
        for (int i = 0; i < K; i++) checkVal(tag, dut.uKeyBank.keyMem[i], 0);
    endtask

    task automatic loadKey(input logic [31:0] base, input bit incr);
        for (int i = 0; i < K; i++) begin
            setIn(1, incr ? base + 32'(i) : base, 0, '0, 1, 0);
            cycle();
        end
        setIn(0, '0, 0, '0, 1, 0);
    endtask

    initial begin
        setIn(0, '0, 0, '0, 0, 0);
        #1;
        // Test 1: reset, then key 1..16 back-to-back
        iRst = 1'b1;
        cycle(); cycle();
        iRst = 1'b0;
        checkVal("rst_state", bus.oState, 0);
        checkVal("rst_valid", bus.oData_valid, 0);
        checkVal("rst_data", bus.oData, 0);
        checkVal("rst_loaded", bus.oKey_loaded, 0);
        checkBankZero("rst_bank");
        loadKey(32'h1, 1);
        checkVal("t1_state", bus.oState, 1);
        checkVal("t1_loaded", bus.oKey_loaded, 1);

        // Test 2: 20 words of all-ones, continuous downstream ready
        for (int i = 0; i < 20; i++) begin
            setIn(0, '0, 1, 32'hFFFF_FFFF, 1, 0);
            cycle();
            checkVal("t2_word", bus.oData, 32'hFFFF_FFFF ^ 32'((i % 16) + 1));
        end
        setIn(0, '0, 0, '0, 1, 0);
        cycle();
`ifdef XOR_CIPHER_WORD_COUNT_EN
        checkVal("t2_count", wordCount, 20);
`endif

        // Test 3: three-cycle downstream stall with data pending upstream
        setIn(0, '0, 1, $urandom, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            setIn(0, '0, 1, $urandom, 0, 0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            setIn(0, '0, 1, $urandom, 1, 0);
            cycle();
        end
        setIn(0, '0, 0, '0, 1, 0);
        cycle();

        // Test 4: rekey together with a data handshake, downstream stalled
        setIn(0, '0, 1, 32'h1234_5678, 0, 1);
        cycle();
        checkVal("t4_drain", bus.oState, 2);
        checkVal("t4_valid", bus.oData_valid, 1);
        setIn(0, '0, 0, '0, 0, 0);
        cycle(); cycle();
        checkVal("t4_hold", bus.oState, 2);
        setIn(0, '0, 0, '0, 1, 0);
        cycle();
        cycle();
        checkVal("t4_load", bus.oState, 0);
        loadKey(32'hA5A5_A5A5, 0);
        setIn(0, '0, 1, '0, 1, 0);
        cycle();
        checkVal("t4_newkey", bus.oData, 32'hA5A5_A5A5);

        // Test 5: key valid in RUN, data valid in LOAD
        for (int i = 0; i < 4; i++) begin
            setIn(1, $urandom, 0, '0, 1, 0);
            cycle();
        end
        setIn(0, '0, 0, '0, 1, 1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            setIn(0, '0, 1, $urandom, 1, 0);
            cycle();
        end
        checkVal("t5_load", bus.oState, 0);
        for (int i = 0; i < 40 && mMode == 0; i++) begin
            setIn($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, 1, 0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            setIn(0, '0, 1, $urandom, $urandom_range(0, 1), 0);
            cycle();
        end

        // Test 6: reset mid-stream
        setIn(0, '0, 1, $urandom, 0, 0);
        iRst = 1'b1;
        cycle();
        iRst = 1'b0;
        checkVal("t6_state", bus.oState, 0);
        checkVal("t6_valid", bus.oData_valid, 0);
        checkBankZero("t6_bank");
`ifdef XOR_CIPHER_WORD_COUNT_EN
        checkVal("t6_count", wordCount, 0);
`endif

        // Randomized traffic with sporadic rekeys and resets
        for (int i = 0; i < 1500; i++) begin
            setIn($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
            iRst = ($urandom_range(0, 299) == 0);
            cycle();
            if (iRst) begin
                iRst = 1'b0;
                checkBankZero("rnd_bank");
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
